// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC output-port arbiter.
// Holds the port index enum, the flit record and the pointer-wrap helper.
package noc_arb_pkg;

  localparam int NUM_REQ = 6;
  localparam int AGE_W   = 4;
  localparam int IDX_W   = 3;
  localparam int ID_W    = 6;
  localparam int FLIT_W  = 8;

  typedef enum logic [IDX_W-1:0] {
    PORT_N = 3'd0,
    PORT_W = 3'd1,
    PORT_S = 3'd2,
    PORT_E = 3'd3,
    PORT_Q = 3'd4,
    PORT_R = 3'd5
  } port_idx_t;

  typedef struct packed {
    logic              qos;
    logic [1:0]        pkt_type;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
    logic [FLIT_W-1:0] data;
  } flit_t;

  // Round-robin pointer successor: the slot after idx, wrapping at n.
  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set finder: returns the first set bit of req at or after ptr,
// as one-hot and as an index, plus a found flag.
module rr_pick #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          found
);

  // Walk the N positions starting at ptr and keep the first requester seen.
  always_comb begin
    logic [IW:0] pos_v;
    gnt_oh  = {N{1'b0}};
    gnt_idx = {IW{1'b0}};
    found   = 1'b0;
    pos_v   = {(IW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      pos_v = {1'b0, ptr} + (IW+1)'(k);
      if (pos_v >= (IW+1)'(N)) begin
        pos_v = pos_v - (IW+1)'(N);
      end else begin
        pos_v = pos_v;
      end
      if (!found && req[pos_v[IW-1:0]]) begin
        gnt_oh[pos_v[IW-1:0]] = 1'b1;
        gnt_idx               = pos_v[IW-1:0];
        found                 = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/port_out_arb.sv
// Output-port arbiter: round-robin over enabled requesters with a QoS/aging
// high class, feeding a single registered output flit with full throughput.
module port_out_arb
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ = noc_arb_pkg::NUM_REQ,
  parameter int ID_W    = noc_arb_pkg::ID_W,
  parameter int FLIT_W  = noc_arb_pkg::FLIT_W,
  parameter int AGE_LIM = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        port_en,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ-1:0]        req_qos,
  input  logic [2*NUM_REQ-1:0]      req_type,
  input  logic [NUM_REQ*ID_W-1:0]   req_src,
  input  logic [NUM_REQ*ID_W-1:0]   req_tgt,
  input  logic [NUM_REQ*FLIT_W-1:0] req_data,
  output logic                      out_vld,
  output logic                      out_qos,
  output logic [1:0]                out_type,
  output logic [ID_W-1:0]           out_src,
  output logic [ID_W-1:0]           out_tgt,
  output logic [FLIT_W-1:0]         out_data,
  input  logic                      out_rdy,
  output logic [2:0]                out_gnt_idx
);

  logic                 load_en_s;
  logic [NUM_REQ-1:0]   elig_s;
  logic [NUM_REQ-1:0]   high_s;
  logic [NUM_REQ-1:0]   high_oh_s;
  logic [NUM_REQ-1:0]   elig_oh_s;
  logic [NUM_REQ-1:0]   gnt_oh_s;
  logic [IDX_W-1:0]     high_idx_s;
  logic [IDX_W-1:0]     elig_idx_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic                 high_found_s;
  logic                 elig_found_s;
  logic                 gnt_vld_s;

  logic                 sel_qos_s;
  logic [1:0]           sel_type_s;
  logic [ID_W-1:0]      sel_src_s;
  logic [ID_W-1:0]      sel_tgt_s;
  logic [FLIT_W-1:0]    sel_data_s;

  logic                 out_vld_r;
  logic                 out_qos_r;
  logic [1:0]           out_type_r;
  logic [ID_W-1:0]      out_src_r;
  logic [ID_W-1:0]      out_tgt_r;
  logic [FLIT_W-1:0]    out_data_r;
  logic [IDX_W-1:0]     out_gnt_idx_r;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [AGE_W-1:0]     age_r [NUM_REQ];

  // The output register can take a new flit when empty or draining this cycle.
  assign load_en_s = !out_vld_r || out_rdy;

  // Eligibility and high-class membership; aged requests join the high class.
  always_comb begin
    elig_s = {NUM_REQ{1'b0}};
    high_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = req_vld[i] & port_en[i];
      high_s[i] = elig_s[i] & (req_qos[i] | (int'(age_r[i]) >= AGE_LIM));
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick_high (
    .req     (high_s),
    .ptr     (rr_ptr_r),
    .gnt_oh  (high_oh_s),
    .gnt_idx (high_idx_s),
    .found   (high_found_s)
  );

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick_elig (
    .req     (elig_s),
    .ptr     (rr_ptr_r),
    .gnt_oh  (elig_oh_s),
    .gnt_idx (elig_idx_s),
    .found   (elig_found_s)
  );

  // High class wins over plain eligibility; no grant at all while in reset.
  always_comb begin
    gnt_oh_s  = {NUM_REQ{1'b0}};
    gnt_idx_s = {IDX_W{1'b0}};
    gnt_vld_s = 1'b0;
    if (rst_n && load_en_s) begin
      if (high_found_s) begin
        gnt_oh_s  = high_oh_s;
        gnt_idx_s = high_idx_s;
        gnt_vld_s = 1'b1;
      end else if (elig_found_s) begin
        gnt_oh_s  = elig_oh_s;
        gnt_idx_s = elig_idx_s;
        gnt_vld_s = 1'b1;
      end else begin
        gnt_vld_s = 1'b0;
      end
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  assign req_rdy = gnt_oh_s;

  // One-hot AND-OR mux of the granted requester's fields.
  always_comb begin
    sel_qos_s  = 1'b0;
    sel_type_s = 2'b00;
    sel_src_s  = {ID_W{1'b0}};
    sel_tgt_s  = {ID_W{1'b0}};
    sel_data_s = {FLIT_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_qos_s  = sel_qos_s  | (req_qos[i] & gnt_oh_s[i]);
      sel_type_s = sel_type_s | (req_type[2*i +: 2] & {2{gnt_oh_s[i]}});
      sel_src_s  = sel_src_s  | (req_src[i*ID_W +: ID_W] & {ID_W{gnt_oh_s[i]}});
      sel_tgt_s  = sel_tgt_s  | (req_tgt[i*ID_W +: ID_W] & {ID_W{gnt_oh_s[i]}});
      sel_data_s = sel_data_s | (req_data[i*FLIT_W +: FLIT_W] & {FLIT_W{gnt_oh_s[i]}});
    end
  end

  // Output flit register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_r     <= 1'b0;
      out_qos_r     <= 1'b0;
      out_type_r    <= 2'b00;
      out_src_r     <= {ID_W{1'b0}};
      out_tgt_r     <= {ID_W{1'b0}};
      out_data_r    <= {FLIT_W{1'b0}};
      out_gnt_idx_r <= {IDX_W{1'b0}};
      rr_ptr_r      <= {IDX_W{1'b0}};
    end else if (load_en_s) begin
      if (gnt_vld_s) begin
        out_vld_r     <= 1'b1;
        out_qos_r     <= sel_qos_s;
        out_type_r    <= sel_type_s;
        out_src_r     <= sel_src_s;
        out_tgt_r     <= sel_tgt_s;
        out_data_r    <= sel_data_s;
        out_gnt_idx_r <= gnt_idx_s;
        rr_ptr_r      <= ptr_after(gnt_idx_s, NUM_REQ);
      end else begin
        out_vld_r <= 1'b0;
      end
    end else begin
      out_vld_r <= out_vld_r;
    end
  end

  // Per-requester wait age: cleared on grant or when idle, saturating otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        age_r[i] <= {AGE_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!elig_s[i] || gnt_oh_s[i]) begin
          age_r[i] <= {AGE_W{1'b0}};
        end else if (age_r[i] != {AGE_W{1'b1}}) begin
          age_r[i] <= age_r[i] + AGE_W'(1);
        end else begin
          age_r[i] <= age_r[i];
        end
      end
    end
  end

  assign out_vld     = out_vld_r;
  assign out_qos     = out_qos_r;
  assign out_type    = out_type_r;
  assign out_src     = out_src_r;
  assign out_tgt     = out_tgt_r;
  assign out_data    = out_data_r;
  assign out_gnt_idx = out_gnt_idx_r;

endmodule

// File: tb/tb_port_out_arb.sv
// Scoreboard bench for port_out_arb: a cycle model predicts each grant, the
// granted flit is queued and compared when it appears in the output register.
module tb_port_out_arb;
  import noc_arb_pkg::*;

  localparam int NR = 6;
  localparam int IW = 6;
  localparam int FW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   port_en;
  logic [NR-1:0]   req_vld;
  logic [NR-1:0]   req_rdy;
  logic [NR-1:0]   req_qos;
  logic [2*NR-1:0] req_type;
  logic [NR*IW-1:0] req_src;
  logic [NR*IW-1:0] req_tgt;
  logic [NR*FW-1:0] req_data;
  logic            out_vld;
  logic            out_qos;
  logic [1:0]      out_type;
  logic [IW-1:0]   out_src;
  logic [IW-1:0]   out_tgt;
  logic [FW-1:0]   out_data;
  logic            out_rdy;
  logic [2:0]      out_gnt_idx;

  int n_cmp = 0;
  int n_err = 0;

  flit_t      exp_q[$];
  logic [2:0] idx_q[$];

  logic [2:0] m_ptr;
  logic [3:0] m_age [NR];
  logic       m_vld;
  flit_t      m_last;
  logic [2:0] m_last_idx;

  always #5 clk = ~clk;

  port_out_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .port_en     (port_en),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_qos     (req_qos),
    .req_type    (req_type),
    .req_src     (req_src),
    .req_tgt     (req_tgt),
    .req_data    (req_data),
    .out_vld     (out_vld),
    .out_qos     (out_qos),
    .out_type    (out_type),
    .out_src     (out_src),
    .out_tgt     (out_tgt),
    .out_data    (out_data),
    .out_rdy     (out_rdy),
    .out_gnt_idx (out_gnt_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] s, input logic [2:0] ptr);
    int p;
    for (int k = 0; k < NR; k++) begin
      p = (int'(ptr) + k) % NR;
      if (s[p]) return p;
    end
    return -1;
  endfunction

  task automatic new_fields();
    req_type = 12'($urandom());
    req_src  = 36'({$urandom(), $urandom()});
    req_tgt  = 36'({$urandom(), $urandom()});
    req_data = 48'({$urandom(), $urandom()});
  endtask

  task automatic model_reset();
    m_ptr      = 3'd0;
    m_vld      = 1'b0;
    m_last     = '0;
    m_last_idx = 3'd0;
    for (int i = 0; i < NR; i++) m_age[i] = 4'd0;
    exp_q.delete();
    idx_q.delete();
  endtask

  // One clock: predict and check req_rdy, queue any grant, advance the model,
  // then compare the output register after the edge.
  task automatic step();
    logic [NR-1:0] elig, high, exp_rdy;
    logic          load, in_rst;
    int            g;
    flit_t         f;
    #1;
    in_rst = !rst_n;
    load   = !m_vld || out_rdy;
    elig   = req_vld & port_en;
    for (int i = 0; i < NR; i++) high[i] = elig[i] && (req_qos[i] || m_age[i] >= 4'd8);
    g = -1;
    if (!in_rst && load) begin
      g = pick(high, m_ptr);
      if (g < 0) g = pick(elig, m_ptr);
    end
    exp_rdy = (g >= 0) ? (6'd1 << g) : 6'd0;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    if (g >= 0) begin
      f.qos      = req_qos[g];
      f.pkt_type = req_type[2*g +: 2];
      f.src      = req_src[g*IW +: IW];
      f.tgt      = req_tgt[g*IW +: IW];
      f.data     = req_data[g*FW +: FW];
      exp_q.push_back(f);
      idx_q.push_back(3'(g));
    end
    @(posedge clk);
    if (in_rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (!elig[i] || i == g) m_age[i] = 4'd0;
        else if (m_age[i] != 4'd15) m_age[i] = m_age[i] + 4'd1;
      end
      if (load) begin
        m_vld = (g >= 0);
        if (g >= 0) m_ptr = 3'((g + 1) % NR);
      end
    end
    #1;
    chk("out_vld", 64'(out_vld), 64'(m_vld));
    if (g >= 0) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 64'(1), 64'(0));
      end else begin
        m_last     = exp_q.pop_front();
        m_last_idx = idx_q.pop_front();
      end
    end
    chk("out_qos",  64'(out_qos),     64'(m_last.qos));
    chk("out_type", 64'(out_type),    64'(m_last.pkt_type));
    chk("out_src",  64'(out_src),     64'(m_last.src));
    chk("out_tgt",  64'(out_tgt),     64'(m_last.tgt));
    chk("out_data", 64'(out_data),    64'(m_last.data));
    chk("out_idx",  64'(out_gnt_idx), 64'(m_last_idx));
  endtask

  initial begin
    model_reset();
    rst_n   = 1'b0;
    port_en = 6'b111111;
    req_vld = 6'b111111;
    req_qos = 6'b000000;
    out_rdy = 1'b1;
    new_fields();

    // Reset held for two cycles with every requester valid.
    step();
    step();

    // Plain round robin: N,W,S,E,Q,R,N with the index one cycle behind.
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      new_fields();
      step();
      chk("rr_order", 64'(out_gnt_idx), 64'(c % NR));
    end

    // Two more grants (W,S) leave the pointer at E with a flit held, then reset.
    for (int c = 0; c < 2; c++) begin
      new_fields();
      step();
    end
    rst_n = 1'b0;
    step();
    chk("mid_rst_vld", 64'(out_vld), 64'(0));
    rst_n = 1'b1;
    new_fields();
    step();
    chk("post_rst_first", 64'(out_gnt_idx), 64'(PORT_N));

    // QoS and aging: W high class, N ages from cycle 0, S joins a cycle later.
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    req_qos = 6'b000010;
    for (int t = 0; t < 12; t++) begin
      req_vld = (t >= 1) ? 6'b000111 : 6'b000011;
      new_fields();
      step();
      if (t < 8) chk("qos_w", 64'(out_gnt_idx), 64'(PORT_W));
      else if (t == 8) chk("age_n", 64'(out_gnt_idx), 64'(PORT_N));
    end

    // Backpressure: five stalled cycles with changing inputs, then release.
    req_vld = 6'b111111;
    req_qos = 6'b010100;
    out_rdy = 1'b0;
    for (int t = 0; t < 5; t++) begin
      new_fields();
      step();
      chk("bp_rdy", 64'(req_rdy), 64'(0));
    end
    out_rdy = 1'b1;
    new_fields();
    step();

    // Port mask: N disabled, everyone valid.
    port_en = 6'b111110;
    req_qos = 6'b000001;
    for (int t = 0; t < 8; t++) begin
      new_fields();
      step();
      chk("mask_n", 64'(req_rdy[0]), 64'(0));
    end

    // Random mix of valids, enables, QoS and downstream stalls.
    for (int t = 0; t < 60; t++) begin
      port_en = 6'($urandom());
      req_vld = 6'($urandom());
      req_qos = 6'($urandom()) & 6'($urandom());
      out_rdy = ($urandom_range(0, 3) != 0);
      new_fields();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
